sprite_palette_lut: RTL and testbench
=====================================

// Module: sprite_palette_lut
// PURPOSE
//  Writable, multi-bank colour palette for sprite rendering. Converts a per-pixel
//  colour index into RGB with a fixed 2-cycle pipeline. Adds transparency keying
//  and a timed "hit flash" override. Sits between sprite ROM index output and the
//  VGA colour mux; one instance serves all sprites of one class, one bank per skin.
// PARAMETERS
//  INDEX_W        4       colour index width; 2**INDEX_W entries per bank
//  NUM_BANKS      4       number of palettes; BANK_W = $clog2(NUM_BANKS), min 1
//  CHAN_W         4       bits per colour channel
//  TRANSPARENT_IDX 0      index reported as transparent in every bank
//  FLASH_RGB      12'hFFF {R,G,B} override colour during flash (3*CHAN_W bits)
//  FLASH_FRAMES   8       frames a flash lasts; FLASH_FRAMES >= 1
// PORTS
//  Clk          in   1           system clock, all logic on rising edge
//  Reset_n      in   1           asynchronous, active-low reset
//  wr_en        in   1           write palette entry this cycle
//  wr_bank      in   BANK_W      bank to write
//  wr_index     in   INDEX_W     entry to write
//  wr_rgb       in   3*CHAN_W    {R,G,B} to store
//  rd_valid_in  in   1           lookup request valid
//  rd_bank      in   BANK_W      bank to look up
//  rd_index     in   INDEX_W     colour index to look up
//  frame_start  in   1           one-cycle pulse at start of each frame
//  flash_req    in   1           one-cycle pulse: start/restart flash
//  rd_valid_out out  1           red/green/blue/transparent valid
//  red          out  CHAN_W      output red
//  green        out  CHAN_W      output green
//  blue         out  CHAN_W      output blue
//  transparent  out  1           pixel is transparent (caller shows background)
//  flash_active out  1           flash counter nonzero
// BEHAVIOUR
//  Reset (async, Reset_n=0): all palette entries = 0; pipeline valids = 0;
//   red/green/blue = 0; transparent = 0; rd_valid_out = 0; flash counter = 0.
//   Reset mid-lookup or mid-flash discards both immediately.
//  Storage: NUM_BANKS x 2**INDEX_W register array of 3*CHAN_W bits.
//   Write committed on the rising edge where wr_en=1; bank/index out of range
//   (NUM_BANKS not power of 2) -> write ignored.
//  Pipeline: stage1 registers {rd_valid_in, rd_bank, rd_index} at edge E0;
//   stage2 registers the lookup at E1; outputs valid after E1 (latency 2, one
//   lookup per cycle, no stall, no backpressure).
//   Lookup in stage1 uses array contents after E0: a write and a read to the
//   same entry presented in the same cycle returns the NEW value.
//   Out-of-range rd_bank -> RGB 0, transparent 0.
//  Outputs update only when stage1 valid=1; with valid=0, rd_valid_out drops to
//   0 and red/green/blue/transparent hold their last values.
//  Transparency: rd_index == TRANSPARENT_IDX -> transparent=1, RGB=0, flash
//   ignored. Otherwise transparent=0.
//  Flash counter (width $clog2(FLASH_FRAMES+1)):
//   flash_req=1 -> load FLASH_FRAMES (reload if already active);
//   else frame_start=1 and counter>0 -> decrement; saturates at 0.
//   flash_req and frame_start same cycle -> load wins, no decrement.
//   flash_active = (counter != 0), registered.
//  Flash override: stage2 samples flash_active at E1; if 1 and pixel opaque,
//   RGB = FLASH_RGB instead of palette entry.
//   Lookups straddling a counter change take the value at their E1 edge.
// TESTING
//  1 Reset: Reset_n=0 mid-stream -> all outputs 0, rd_valid_out 0 same cycle;
//    read bank0 idx5 after release -> RGB 000.
//  2 Write bank2 idx3=12'hA01, read bank2 idx3 -> 2 cycles later RGB A,0,1,
//    valid=1; same-cycle write 12'h050 + read idx3 -> returns 0,5,0.
//  3 Back-to-back reads idx1..15 bank1 -> 15 consecutive valid outputs, order
//    kept; idx0 -> transparent=1, RGB 000.
//  4 flash_req, then 8 frame_start pulses -> flash_active 1 for exactly 8
//    frames; opaque reads return F,F,F, transparent reads still 000.
//  5 flash_req coincident with frame_start at counter=3 -> counter = 8;
//    flash_req at counter=1 -> no drop of flash_active.
//  6 Bank isolation: write bank0 idx4=12'hF76, bank3 idx4=12'h000 -> reads
//    differ; NUM_BANKS=3 build: write/read bank3 -> ignored / RGB 000.

Source files
------------

// File: rtl/sprite_palette_lut.sv
// Multi-bank sprite colour palette: index -> RGB in a fixed two-stage pipeline,
// with transparency keying and a frame-timed hit-flash override.
module sprite_palette_lut #(
    parameter int INDEX_W = 4,
    parameter int NUM_BANKS = 4,
    parameter int CHAN_W = 4,
    parameter int TRANSPARENT_IDX = 0,
    parameter logic [3*CHAN_W-1:0] FLASH_RGB = 12'hFFF,
    parameter int FLASH_FRAMES = 8,
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int RGB_W = 3 * CHAN_W,
    localparam int CNT_W = $clog2(FLASH_FRAMES + 1)
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               wr_en,
    input  logic [BANK_W-1:0]  wr_bank,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [RGB_W-1:0]   wr_rgb,
    input  logic               rd_valid_in,
    input  logic [BANK_W-1:0]  rd_bank,
    input  logic [INDEX_W-1:0] rd_index,
    input  logic               frame_start,
    input  logic               flash_req,
    output logic               rd_valid_out,
    output logic [CHAN_W-1:0]  red,
    output logic [CHAN_W-1:0]  green,
    output logic [CHAN_W-1:0]  blue,
    output logic               transparent,
    output logic               flash_active
);

    localparam int ENTRIES = 2 ** INDEX_W;

    logic [RGB_W-1:0]   mem [NUM_BANKS][ENTRIES];
    logic               s1_valid;
    logic [BANK_W-1:0]  s1_bank;
    logic [INDEX_W-1:0] s1_index;
    logic [CNT_W-1:0]   flash_cnt;
    logic [CNT_W-1:0]   flash_nxt;
    logic               wr_ok;
    logic               rd_ok;
    logic               rd_trans;
    logic [RGB_W-1:0]   entry;
    logic [RGB_W-1:0]   rgb_nxt;

    assign wr_ok    = int'(wr_bank) < NUM_BANKS;
    assign rd_ok    = int'(s1_bank) < NUM_BANKS;
    assign rd_trans = rd_ok && (s1_index == INDEX_W'(TRANSPARENT_IDX));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    mem[b][i] <= '0;
                end
            end
        end else if (wr_en && wr_ok) begin
            mem[wr_bank][wr_index] <= wr_rgb;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid <= 1'b0;
            s1_bank  <= '0;
            s1_index <= '0;
        end else begin
            s1_valid <= rd_valid_in;
            s1_bank  <= rd_bank;
            s1_index <= rd_index;
        end
    end

    // Stage-1 lookup sees the array after this cycle's write has landed.
    always_comb begin
        entry = '0;
        if (rd_ok) begin
            entry = mem[s1_bank][s1_index];
        end
    end

    always_comb begin
        rgb_nxt = entry;
        unique case (1'b1)
            (!rd_ok || rd_trans):                  rgb_nxt = '0;
            (rd_ok && !rd_trans && flash_active):  rgb_nxt = FLASH_RGB;
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_valid_out <= 1'b0;
            red          <= '0;
            green        <= '0;
            blue         <= '0;
            transparent  <= 1'b0;
        end else begin
            rd_valid_out <= s1_valid;
            if (s1_valid) begin
                {red, green, blue} <= rgb_nxt;
                transparent        <= rd_trans;
            end
        end
    end

    always_comb begin
        flash_nxt = flash_cnt;
        if (flash_req) begin
            flash_nxt = CNT_W'(FLASH_FRAMES);
        end else if (frame_start && (flash_cnt != '0)) begin
            flash_nxt = flash_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            flash_cnt    <= '0;
            flash_active <= 1'b0;
        end else begin
            flash_cnt    <= flash_nxt;
            flash_active <= (flash_nxt != '0);
        end
    end

endmodule

// File: tb/tb_sprite_palette_lut.sv
// Scoreboard bench for sprite_palette_lut: driver feeds a palette/flash model,
// monitor pops expected pixels whenever rd_valid_out is presented.
module tb_sprite_palette_lut;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_bank = '0;
    logic [3:0]  wr_index = '0;
    logic [11:0] wr_rgb = '0;
    logic        rd_valid_in = 1'b0;
    logic [1:0]  rd_bank = '0;
    logic [3:0]  rd_index = '0;
    logic        frame_start = 1'b0;
    logic        flash_req = 1'b0;
    logic        rd_valid_out;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        transparent;
    logic        flash_active;

    sprite_palette_lut dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_index(wr_index), .wr_rgb(wr_rgb),
        .rd_valid_in(rd_valid_in), .rd_bank(rd_bank), .rd_index(rd_index),
        .frame_start(frame_start), .flash_req(flash_req),
        .rd_valid_out(rd_valid_out), .red(red), .green(green), .blue(blue),
        .transparent(transparent), .flash_active(flash_active)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [11:0] rgb;
        logic        tr;
    } exp_t;

    exp_t        q[$];
    exp_t        last = '0;
    logic [11:0] pal [4][16];
    int          cnt = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [12:0] got,
                       input logic [12:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    always @(negedge Clk) begin
        if (Reset_n) begin
            if (rd_valid_out) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid got 1 want 0");
                end else begin
                    last = q.pop_front();
                    chk("lookup", {red, green, blue, transparent},
                        {last.rgb, last.tr});
                end
            end else begin
                chk("hold", {red, green, blue, transparent}, {last.rgb, last.tr});
            end
            chk("pending", 13'(q.size() <= 1), 13'd1);
            chk("flash_active", {12'b0, flash_active}, {12'b0, cnt != 0});
        end
    end

    task automatic clear_model();
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < 16; i++)
                pal[b][i] = '0;
        cnt = 0;
        q.delete();
        last = '0;
    endtask

    task automatic step(input logic we, input logic [1:0] wb,
                        input logic [3:0] wi, input logic [11:0] wrgb,
                        input logic re, input logic [1:0] rb,
                        input logic [3:0] ri, input logic fs, input logic fq);
        exp_t e;
        wr_en = we; wr_bank = wb; wr_index = wi; wr_rgb = wrgb;
        rd_valid_in = re; rd_bank = rb; rd_index = ri;
        frame_start = fs; flash_req = fq;
        @(posedge Clk);
        if (we) pal[wb][wi] = wrgb;
        if (fq) cnt = 8;
        else if (fs && cnt > 0) cnt = cnt - 1;
        if (re) begin
            if (ri == 4'd0) begin
                e.rgb = 12'h000; e.tr = 1'b1;
            end else if (cnt != 0) begin
                e.rgb = 12'hFFF; e.tr = 1'b0;
            end else begin
                e.rgb = pal[rb][ri]; e.tr = 1'b0;
            end
            q.push_back(e);
        end
        #1;
    endtask

    task automatic wr(input logic [1:0] b, input logic [3:0] i,
                      input logic [11:0] c);
        step(1'b1, b, i, c, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [1:0] b, input logic [3:0] i,
                      input logic fs, input logic fq);
        step(1'b0, 2'd0, 4'd0, 12'h0, 1'b1, b, i, fs, fq);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            step(1'b0, 2'd0, 4'd0, 12'h0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic apply_reset();
        wr_en = 0; rd_valid_in = 0; frame_start = 0; flash_req = 0;
        #2 Reset_n = 1'b0;
        #1;
        chk("reset_rgb", {red, green, blue, transparent}, 13'h0);
        chk("reset_valid", {12'b0, rd_valid_out}, 13'h0);
        chk("reset_flash", {12'b0, flash_active}, 13'h0);
        clear_model();
        repeat (2) @(negedge Clk);
        #1 Reset_n = 1'b1;
    endtask

    initial begin
        clear_model();
        @(negedge Clk);
        chk("init_rgb", {red, green, blue, transparent}, 13'h0);
        chk("init_valid", {12'b0, rd_valid_out}, 13'h0);
        #1 Reset_n = 1'b1;

        rd(2'd0, 4'd5, 1'b0, 1'b0);
        idle(2);

        wr(2'd2, 4'd3, 12'hA01);
        rd(2'd2, 4'd3, 1'b0, 1'b0);
        step(1'b1, 2'd2, 4'd3, 12'h050, 1'b1, 2'd2, 4'd3, 1'b0, 1'b0);
        idle(3);

        for (int i = 0; i < 16; i++)
            wr(2'd1, 4'(i), 12'($urandom_range(1, 4095)));
        for (int i = 1; i < 16; i++)
            rd(2'd1, 4'(i), 1'b0, 1'b0);
        rd(2'd1, 4'd0, 1'b0, 1'b0);
        idle(3);

        rd(2'd1, 4'd7, 1'b0, 1'b1);
        for (int f = 0; f < 9; f++) begin
            rd(2'd1, 4'(f + 1), 1'b1, 1'b0);
            rd(2'd1, 4'd0, 1'b0, 1'b0);
            rd(2'd2, 4'd3, 1'b0, 1'b0);
        end
        idle(3);

        step(1'b0, 2'd0, 4'd0, 12'h0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b1);
        for (int f = 0; f < 5; f++) rd(2'd1, 4'd2, 1'b1, 1'b0);
        rd(2'd1, 4'd2, 1'b1, 1'b1);
        for (int f = 0; f < 7; f++) rd(2'd1, 4'd3, 1'b1, 1'b0);
        rd(2'd1, 4'd3, 1'b0, 1'b1);
        for (int f = 0; f < 8; f++) rd(2'd2, 4'd3, 1'b1, 1'b0);
        idle(3);

        wr(2'd0, 4'd4, 12'hF76);
        wr(2'd3, 4'd4, 12'h000);
        rd(2'd0, 4'd4, 1'b0, 1'b0);
        rd(2'd3, 4'd4, 1'b0, 1'b0);
        rd(2'd1, 4'd4, 1'b0, 1'b0);
        rd(2'd2, 4'd9, 1'b0, 1'b0);
        apply_reset();
        rd(2'd0, 4'd5, 1'b0, 1'b0);
        rd(2'd2, 4'd3, 1'b0, 1'b0);
        idle(3);

        for (int k = 0; k < 400; k++)
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)), 12'($urandom),
                 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 39) == 0));
        rd(2'd1, 4'd6, 1'b0, 1'b0);
        rd(2'd2, 4'd6, 1'b0, 1'b0);
        apply_reset();
        for (int k = 0; k < 100; k++)
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)), 12'($urandom),
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 29) == 0));
        idle(4);
        chk("drain", 13'(q.size()), 13'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
